uart_tx_drain: RTL



---
 rtl/uart_tx_drain_pkg.sv | 12 +
 rtl/uart_tx_drain_if.sv | 10 +
 rtl/uart_tx_drain_parity.sv | 13 +
 rtl/uart_tx_drain.sv | 80 ++++++++
 4 files changed

// File: rtl/uart_tx_drain_pkg.sv
// uart_tx_drain_pkg: state encoding and parity-type constants shared by the UART drain block
package uart_tx_drain_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_tx_drain_if.sv
// uart_tx_drain_if: FIFO read-port bundle (empty flag, head word, pop strobe)
//   master: drain side, consumes empty/data, drives fifo_rd_inc
//   slave : FIFO side, drives empty/data, consumes fifo_rd_inc
interface uart_tx_drain_if #(parameter int DATA_WIDTH = 8);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_inc;
    modport master (input fifo_empty, fifo_rd_data, output fifo_rd_inc);
    modport slave  (output fifo_empty, fifo_rd_data, input fifo_rd_inc);
endinterface

// File: rtl/uart_tx_drain_parity.sv
// uart_tx_parity: combinational parity bit generator
//   data    : word to protect
//   par_typ : PAR_EVEN / PAR_ODD
//   par_bit : parity bit to place on the line
module uart_tx_parity import uart_tx_drain_pkg::*; #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);
    assign par_bit = (^data) ^ (par_typ == PAR_ODD);
endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops the async FIFO read side and serializes each word as a UART frame
//   clk, rst_n      : bit clock (FIFO read clock), async active-low reset
//   fifo            : FIFO read port (empty, head word, pop strobe)
//   par_en, par_typ : parity enable / type, latched per frame at the pop
//   tx_out, busy    : registered serial line (idles high) and frame-in-progress flag
module uart_tx_drain import uart_tx_drain_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_drain_if.master   fifo,
    input  logic              par_en,
    input  logic              par_typ,
    output logic              tx_out,
    output logic              busy
);
    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] shift, shift_nxt;
    logic                  par_en_q, par_bit_q, par_bit, pop, tx_nxt;

    assign pop = (state == IDLE || state == STOP) && !fifo.fifo_empty;
    assign fifo.fifo_rd_inc = pop;

    uart_tx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .data    (fifo.fifo_rd_data),
        .par_typ (par_typ),
        .par_bit (par_bit)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_nxt = shift;
        case (state)
            IDLE, STOP: begin
                state_nxt = pop ? START : IDLE;
                shift_nxt = pop ? fifo.fifo_rd_data : shift;
            end
            START: begin
                state_nxt = DATA;
                cnt_nxt   = '0;
            end
            DATA: begin
                shift_nxt = shift >> 1;
                state_nxt = (cnt == CNT_WIDTH'(DATA_WIDTH - 1)) ? (par_en_q ? PARITY : STOP) : DATA;
                cnt_nxt   = (cnt == CNT_WIDTH'(DATA_WIDTH - 1)) ? cnt : cnt + 1'b1;
            end
            PARITY:  state_nxt = STOP;
            default: state_nxt = IDLE;
        endcase
        // line value is registered, so derive it from the state and shift contents about to be entered
        tx_nxt = (state_nxt == START)  ? 1'b0 :
                 (state_nxt == DATA)   ? shift_nxt[0] :
                 (state_nxt == PARITY) ? par_bit_q : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shift  <= shift_nxt;
            tx_out <= tx_nxt;
            busy   <= state_nxt != IDLE;
            if (pop) begin
                par_en_q  <= par_en;
                par_bit_q <= par_bit;
            end
        end
    end
endmodule
